cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/instr_decoder.sv | 42 ++++
 rtl/cpu_controller.sv | 124 ++++++++++++
 tb/tb_cpu_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and vsel encodings for the cpu controller
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN,
    CLS_ILLEGAL
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC     = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - field extraction, sign extension and class decode of the IR
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output iclass_t     cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle Moore controller sequencing datapath strobes per instruction
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t     state, next_state;
  logic [15:0] ir;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh, op;
  iclass_t    cls;

  instr_decoder u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm8 (sximm8),
    .sximm5 (sximm5),
    .cls    (cls)
  );

  // IR only loads on the edge that leaves WAIT, so it holds for the whole instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  always_comb begin
    next_state = state;
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = '0;
    writenum = '0;
    vsel     = VSEL_MDATA;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                next_state = S_WRITE_IMM;
          CLS_ADD, CLS_CMP, CLS_AND:  next_state = S_GET_A;
          CLS_MOV_REG, CLS_MVN:       next_state = S_GET_B;
          default: begin
            illegal    = 1'b1;
            next_state = S_WAIT;
          end
        endcase
      end
      S_WRITE_IMM: begin
        vsel       = VSEL_SXIMM8;
        writenum   = rn;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        // single-operand ops zero the A input so the ALU passes/inverts B
        shift      = sh;
        asel       = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        ALUop      = (cls == CLS_MOV_REG) ? 2'b00 : op;
        loadc      = (cls != CLS_CMP);
        loads      = (cls == CLS_CMP);
        next_state = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        vsel       = VSEL_C;
        writenum   = rd;
        write      = 1'b1;
        shift      = sh;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for the cpu controller
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w, illegal, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (in),
    .w        (w),
    .illegal  (illegal),
    .readnum  (readnum),
    .writenum (writenum),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {w, illegal, readnum, writenum, vsel, loada, loadb, loadc,
                loads, write, asel, bsel, shift, ALUop};

  function automatic logic [20:0] mk(logic ww, logic ill, logic [2:0] rnum,
                                     logic [2:0] wnum, logic [1:0] vs,
                                     logic la, logic lb, logic lc, logic ls,
                                     logic wr, logic as, logic bs,
                                     logic [1:0] sh, logic [1:0] alu);
    return {ww, ill, rnum, wnum, vs, la, lb, lc, ls, wr, as, bs, sh, alu};
  endfunction

  task automatic push(input string tag, input logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_next();
    exp_t e;
    e = q.pop_front();
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse s for one accept edge; afterwards in is scrambled to prove it is ignored
  task automatic start(input logic [15:0] instr);
    s  = 1'b1;
    in = instr;
    cyc();
    s  = 1'b0;
    in = 16'($urandom);
  endtask

  task automatic drain();
    while (q.size() != 0) begin
      check_next();
      if (q.size() != 0) cyc();
    end
  endtask

  logic [20:0] v_wait, v_zero;

  initial begin
    v_wait = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    v_zero = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    reset = 1'b1;
    s     = 1'b0;
    in    = 16'hFFFF;
    #12;
    push("reset_state", v_wait);
    check_next();
    check16("reset_sximm8", sximm8, 16'h0000);
    check16("reset_sximm5", sximm5, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // MOV R1,#7
    push("movi_decode", v_zero);
    push("movi_write",  mk(0, 0, 0, 3'd1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    push("movi_wait",   v_wait);
    start(16'hD107);
    check16("movi_sximm8", sximm8, 16'h0007);
    drain();

    // ADD R5,R2,R0,LSL#1
    push("add_decode", v_zero);
    push("add_geta",   mk(0, 0, 3'd2, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("add_getb",   mk(0, 0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("add_exec",   mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00));
    push("add_wreg",   mk(0, 0, 0, 3'd5, 2'b11, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00));
    push("add_wait",   v_wait);
    start(16'hA2A8);
    check16("add_sximm5", sximm5, 16'h0008);
    drain();

    // CMP R1,R3
    push("cmp_decode", v_zero);
    push("cmp_geta",   mk(0, 0, 3'd1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("cmp_getb",   mk(0, 0, 3'd3, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("cmp_exec",   mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
    push("cmp_wait",   v_wait);
    start(16'hA903);
    drain();

    // Undefined opcode 111
    push("ill_decode", mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("ill_wait",   v_wait);
    start(16'hE000);
    drain();

    // Undefined op 01 under the MOV opcode
    push("ill2_decode", mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("ill2_wait",   v_wait);
    start(16'hC800);
    drain();

    // MOV R3,R1,LSR
    push("movr_decode", v_zero);
    push("movr_getb",   mk(0, 0, 3'd1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("movr_exec",   mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2'b00));
    push("movr_wreg",   mk(0, 0, 0, 3'd3, 2'b11, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00));
    push("movr_wait",   v_wait);
    start(16'hC071);
    drain();

    // MVN R2,R4
    push("mvn_decode", v_zero);
    push("mvn_getb",   mk(0, 0, 3'd4, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("mvn_exec",   mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b11));
    push("mvn_wreg",   mk(0, 0, 0, 3'd2, 2'b11, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    push("mvn_wait",   v_wait);
    start(16'hB844);
    drain();

    // Reset during GET_B of an ADD
    push("rst_decode", v_zero);
    push("rst_geta",   mk(0, 0, 3'd2, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    push("rst_getb",   mk(0, 0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    start(16'hA2A8);
    drain();
    #2;
    reset = 1'b1;
    #1;
    push("rst_midop", v_wait);
    check_next();
    check16("rst_midop_sximm8", sximm8, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    push("post_rst_decode", v_zero);
    push("post_rst_write",  mk(0, 0, 0, 3'd1, 2'b01, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    push("post_rst_wait",   v_wait);
    start(16'hD107);
    drain();

    // s held high: MOV R0,#-1 then MOV R2,#5 after exactly one WAIT cycle
    s  = 1'b1;
    in = 16'hD0FF;
    cyc();
    push("b2b_decode1", v_zero);
    check_next();
    check16("b2b_sximm8_neg", sximm8, 16'hFFFF);
    check16("b2b_sximm5_neg", sximm5, 16'hFFFF);
    in = 16'hD205;
    cyc();
    push("b2b_write1", mk(0, 0, 0, 3'd0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    check_next();
    cyc();
    push("b2b_wait", v_wait);
    check_next();
    cyc();
    push("b2b_decode2", v_zero);
    check_next();
    check16("b2b_sximm8_2", sximm8, 16'h0005);
    s = 1'b0;
    cyc();
    push("b2b_write2", mk(0, 0, 0, 3'd2, 2'b01, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    check_next();
    cyc();
    push("b2b_end", v_wait);
    check_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
